// File: rtl/alu_result_stage.sv
// ALU result buffer: small FIFO of writeback beats between the ALU and the
// register file, plus the architectural flag register and branch-condition logic.
module alu_result_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] alu_out,
   input  logic [3:0]  alu_szcv,
   input  logic [3:0]  alu_ctl,
   input  logic [2:0]  rd,
   input  logic        flag_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [2:0]  out_rd,
   output logic        out_wen,
   output logic [3:0]  flags,
   input  logic [2:0]  cond_sel,
   output logic        cond_true
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   count_t;

   localparam ptr_t   PTR_LAST   = ptr_t'(DEPTH - 1);
   localparam count_t COUNT_FULL = count_t'(DEPTH);

   // Entry layout: {data[15:0], rd[2:0], wen}
   logic [19:0] entry_mem [DEPTH];

   ptr_t       wr_ptr_q, wr_ptr_d;
   ptr_t       rd_ptr_q, rd_ptr_d;
   count_t     count_q,  count_d;
   logic [3:0] flags_q,  flags_d;

   logic       push;
   logic       pop;
   logic       beat_wen;
   logic       beat_sets_flags;
   logic [19:0] head_entry;

   // Handshake status depends only on registered occupancy, never on out_ready.
   assign in_ready  = (count_q < COUNT_FULL);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Defined register-writing opcodes are 0-4 and 6; CMP (5) only sets flags.
   always_comb begin
      beat_wen        = 1'b0;
      beat_sets_flags = 1'b0;
      if (alu_ctl <= 4'd4 || alu_ctl == 4'd6) begin
         beat_wen = 1'b1;
      end
      if (alu_ctl <= 4'd6) begin
         beat_sets_flags = flag_en;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      flags_d  = flags_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ptr_t'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + count_t'(1);
         2'b01:   count_d = count_q - count_t'(1);
         default: count_d = count_q;
      endcase

      // Flags commit when the beat is accepted, regardless of when it drains.
      if (push && beat_sets_flags) begin
         flags_d = alu_szcv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         flags_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         flags_q  <= flags_d;
      end
   end

   // Entry storage carries no reset; a reset cycle blocks the write instead.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         entry_mem[wr_ptr_q] <= {alu_out, rd, beat_wen};
      end
   end

   assign head_entry = entry_mem[rd_ptr_q];
   assign out_data   = head_entry[19:4];
   assign out_rd     = head_entry[3:1];
   assign out_wen    = head_entry[0];
   assign flags      = flags_q;

   logic flag_s, flag_z, flag_c, flag_v;
   assign {flag_s, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_true = 1'b0;
      case (cond_sel)
         3'd0: cond_true = 1'b1;
         3'd1: cond_true = flag_z;
         3'd2: cond_true = ~flag_z;
         3'd3: cond_true = flag_s ^ flag_v;
         3'd4: cond_true = ~(flag_s ^ flag_v) & ~flag_z;
         3'd5: cond_true = flag_c;
         3'd6: cond_true = ~flag_c;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios followed by random traffic.
module tb_alu_result_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_out;
   logic [3:0]  alu_szcv;
   logic [3:0]  alu_ctl;
   logic [2:0]  rd;
   logic        flag_en;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_rd;
   logic        out_wen;
   logic [3:0]  flags;
   logic [2:0]  cond_sel;
   logic        cond_true;

   always #5 clk = ~clk;

   alu_result_stage #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .alu_szcv(alu_szcv), .alu_ctl(alu_ctl), .rd(rd), .flag_en(flag_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .out_wen(out_wen),
      .flags(flags), .cond_sel(cond_sel), .cond_true(cond_true)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  rd;
      logic        wen;
   } beat_t;

   beat_t      exp_q[$];
   logic [3:0] ref_flags = 4'h0;
   bit         known = 1'b0;
   int         checks = 0;
   int         failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Branch conditions written from their meaning: equal, less/greater signed, carry.
   function automatic logic ref_cond(input logic [3:0] f, input logic [2:0] sel);
      logic s, z, c, v;
      {s, z, c, v} = f;
      case (sel)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return (s != v);
         3'd4: return (s == v) && !z;
         3'd5: return c;
         3'd6: return !c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic ref_wen(input logic [3:0] ctl);
      return (ctl inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6});
   endfunction

   // Monitor + predictor, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      int  occ;
      bit  will_push, will_pop;
      beat_t e;
      if (known) begin
         occ       = exp_q.size();
         will_push = in_valid && (occ < DEPTH) && !rst;
         will_pop  = out_ready && (occ != 0) && !rst;
         check("in_ready", 32'(in_ready), 32'(occ < DEPTH));
         check("out_valid", 32'(out_valid), 32'(occ != 0));
         check("flags", 32'(flags), 32'(ref_flags));
         check("cond_true", 32'(cond_true), 32'(ref_cond(ref_flags, cond_sel)));
         if (will_pop) begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_rd", 32'(out_rd), 32'(e.rd));
            check("out_wen", 32'(out_wen), 32'(e.wen));
            $display("pop data=%04h rd=%0d wen=%0d (expected %04h %0d %0d)",
                     out_data, out_rd, out_wen, e.data, e.rd, e.wen);
         end
         if (will_push) begin
            exp_q.push_back('{data: alu_out, rd: rd, wen: ref_wen(alu_ctl)});
            if (flag_en && alu_ctl <= 4'd6) ref_flags = alu_szcv;
         end
      end
      if (rst) begin
         exp_q.delete();
         ref_flags = 4'h0;
         known     = 1'b1;
      end
   end

   task automatic drive(input logic [15:0] d, input logic [2:0] r, input logic [3:0] ctl,
                        input logic fe, input logic [3:0] szcv);
      in_valid = 1'b1;
      alu_out  = d;
      rd       = r;
      alu_ctl  = ctl;
      flag_en  = fe;
      alu_szcv = szcv;
   endtask

   // Waits for acceptance with a bounded budget, then leaves in_valid low.
   task automatic wait_accept(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_accept actual=timeout required=accepted", name);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input string name, input logic [15:0] d, input logic [2:0] r,
                       input logic [3:0] ctl, input logic fe, input logic [3:0] szcv);
      drive(d, r, ctl, fe, szcv);
      wait_accept(name);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cond_sel = 3'd0;
      alu_out = '0; alu_szcv = '0; alu_ctl = '0; rd = '0; flag_en = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Single beat
      send("single", 16'h1234, 3'd3, 4'd0, 1'b1, 4'h0);
      idle(2);

      // Fill and stall, third beat held until room appears
      out_ready = 1'b0;
      send("fill1", 16'h0001, 3'd1, 4'd1, 1'b0, 4'h0);
      send("fill2", 16'h0002, 3'd2, 4'd2, 1'b0, 4'h0);
      drive(16'h0003, 3'd3, 4'd3, 1'b0, 4'h0);
      idle(3);
      out_ready = 1'b1;
      wait_accept("fill3");
      idle(3);

      // Back-to-back stream
      for (int i = 0; i < 8; i++) send("stream", 16'h0010 + 16'(i), 3'(i), 4'd4, 1'b0, 4'h0);
      idle(3);

      // CMP and undefined opcode
      send("cmp", 16'h0055, 3'd5, 4'd5, 1'b1, 4'h4);
      cond_sel = 3'd1; idle(1);
      cond_sel = 3'd2; idle(1);
      send("undef", 16'h0099, 3'd6, 4'd9, 1'b1, 4'h8);
      idle(2);

      // Signed and carry conditions
      send("fl_s", 16'h0100, 3'd0, 4'd0, 1'b1, 4'h8);
      cond_sel = 3'd3; idle(1);
      cond_sel = 3'd4; idle(1);
      send("fl_sv", 16'h0101, 3'd0, 4'd0, 1'b1, 4'h9);
      cond_sel = 3'd3; idle(1);
      cond_sel = 3'd4; idle(1);
      send("fl_c", 16'h0102, 3'd0, 4'd6, 1'b1, 4'h2);
      cond_sel = 3'd5; idle(1);
      cond_sel = 3'd6; idle(1);

      // Reset while full with a beat on the input
      out_ready = 1'b0;
      send("pre1", 16'h0A01, 3'd1, 4'd0, 1'b1, 4'hF);
      send("pre2", 16'h0A02, 3'd2, 4'd0, 1'b0, 4'h0);
      drive(16'hDEAD, 3'd7, 4'd0, 1'b1, 4'h5);
      rst = 1'b1;
      idle(1);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      idle(3);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         alu_out   = 16'($urandom);
         rd        = 3'($urandom);
         alu_ctl   = 4'($urandom);
         flag_en   = 1'($urandom);
         alu_szcv  = 4'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         cond_sel  = 3'($urandom);
         rst       = ($urandom_range(0, 99) == 0);
         idle(1);
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

      // Drain with a bounded budget
      begin
         bit drained = 1'b0;
         for (int i = 0; i < 20; i++) begin
            idle(1);
            if (exp_q.size() == 0) begin
               drained = 1'b1;
               break;
            end
         end
         check("drain_empty", 32'(drained), 32'd1);
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
